// File: rtl/pid_pkg.sv
// Shared types, default widths and saturation helper for the PID datapath
// and the downstream motor-mix stage.
package pid_pkg;

    localparam int PID_DATA_W  = 16;
    localparam int PID_GAIN_W  = 16;
    localparam int PID_FRAC_W  = 8;
    localparam int PID_INT_LIM = 131071;
    localparam int PID_OUT_MAX = 32767;
    localparam int PID_OUT_MIN = -32768;

    // Integrator/multiplier operand width and accumulator width.
    localparam int PID_INT_W   = PID_DATA_W + 4;
    localparam int PID_ACC_W   = PID_GAIN_W + PID_DATA_W + 8;

    typedef enum logic [2:0] {
        IDLE,
        CAPTURE,
        MUL_P,
        MUL_I,
        MUL_D,
        SUM
    } pid_state_t;

    // Clamp a wide signed value into [lo, hi]; the caller truncates to its width.
    function automatic logic signed [63:0] sat_to_w(
        input logic signed [63:0] value,
        input logic signed [63:0] lo,
        input logic signed [63:0] hi
    );
        if (value > hi)
            return hi;
        else if (value < lo)
            return lo;
        else
            return value;
    endfunction

endpackage

// File: rtl/pid_mac.sv
// Shared signed multiplier with a load/accumulate register.
// load=1 starts a new sum with the product; otherwise the product is added.
module pid_mac #(
    parameter int A_W   = pid_pkg::PID_GAIN_W,
    parameter int B_W   = pid_pkg::PID_INT_W,
    parameter int ACC_W = pid_pkg::PID_ACC_W
) (
    input  logic                    clk_12mhz,
    input  logic                    reset_n,
    input  logic                    clr,
    input  logic                    en,
    input  logic                    load,
    input  logic signed [A_W-1:0]   gain,
    input  logic signed [B_W-1:0]   operand,
    output logic signed [ACC_W-1:0] acc
);

    localparam int PROD_W = A_W + B_W;

    logic signed [PROD_W-1:0] product;
    logic signed [ACC_W-1:0]  product_ext;

    // Full-precision product, sign-extended to the accumulator width.
    assign product     = PROD_W'(gain) * PROD_W'(operand);
    assign product_ext = ACC_W'(product);

    // Accumulator register: clear on abort, load or add when enabled.
    always_ff @(posedge clk_12mhz or negedge reset_n) begin
        if (!reset_n)
            acc <= '0;
        else if (clr)
            acc <= '0;
        else if (en)
            acc <= load ? product_ext : acc + product_ext;
    end

endmodule

// File: rtl/pid_axis_update.sv
// Per-axis PID update: sequences P, I and D terms through one shared MAC
// and produces a saturated command with a one-cycle out_valid strobe.
module pid_axis_update
    import pid_pkg::*;
#(
    parameter int DATA_W  = PID_DATA_W,
    parameter int GAIN_W  = PID_GAIN_W,
    parameter int FRAC_W  = PID_FRAC_W,
    parameter int INT_LIM = PID_INT_LIM,
    parameter int OUT_MAX = PID_OUT_MAX,
    parameter int OUT_MIN = PID_OUT_MIN
) (
    input  logic              clk_12mhz,
    input  logic              reset_n,
    input  logic              pid_clk_en,
    input  logic              enable,
    input  logic [DATA_W-1:0] setpoint,
    input  logic [DATA_W-1:0] measurement,
    input  logic [GAIN_W-1:0] kp,
    input  logic [GAIN_W-1:0] ki,
    input  logic [GAIN_W-1:0] kd,
    output logic [DATA_W-1:0] out,
    output logic              out_valid,
    output logic              busy,
    output logic              overrun
);

    localparam int ERR_W  = DATA_W + 1;
    localparam int DIFF_W = DATA_W + 2;
    localparam int INT_W  = DATA_W + 4;
    localparam int ACC_W  = GAIN_W + DATA_W + 8;
    localparam logic [DATA_W-1:0] OUT_MAX_W = DATA_W'(OUT_MAX);
    localparam logic [DATA_W-1:0] OUT_MIN_W = DATA_W'(OUT_MIN);

    pid_state_t               state, next_state;
    logic signed [ERR_W-1:0]  err, err_prev, err_in;
    logic signed [DIFF_W-1:0] diff;
    logic signed [INT_W-1:0]  integ, integ_next;
    logic signed [INT_W:0]    integ_sum;
    logic                     windup_hold;
    logic                     mac_en, mac_load;
    logic signed [GAIN_W-1:0] mac_gain;
    logic signed [INT_W-1:0]  mac_operand;
    logic signed [ACC_W-1:0]  acc, acc_scaled;
    logic [DATA_W-1:0]        out_next;

    // One extra bit keeps setpoint - measurement exact.
    assign err_in = $signed({setpoint[DATA_W-1], setpoint})
                  - $signed({measurement[DATA_W-1], measurement});

    assign integ_sum  = $signed({integ[INT_W-1], integ})
                      + $signed({{(INT_W + 1 - ERR_W){err[ERR_W-1]}}, err});
    assign integ_next = INT_W'(sat_to_w(64'(integ_sum), 64'(-INT_LIM), 64'(INT_LIM)));

    // Freeze the integrator while the command is pinned and the error pushes further out.
    assign windup_hold = ((out == OUT_MAX_W) && !err[ERR_W-1] && (err != '0))
                      || ((out == OUT_MIN_W) && err[ERR_W-1]);

    // Arithmetic shift floors toward -inf before saturation.
    assign acc_scaled = acc >>> FRAC_W;
    assign out_next   = DATA_W'(sat_to_w(64'(acc_scaled), 64'(OUT_MIN), 64'(OUT_MAX)));

    assign busy = (state != IDLE);

    // State register.
    always_ff @(posedge clk_12mhz or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= next_state;
    end

    // Next-state and MAC operand selection.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch behind.
        next_state  = state;
        mac_en      = 1'b0;
        mac_load    = 1'b0;
        mac_gain    = $signed(kp);
        mac_operand = $signed({{(INT_W - ERR_W){err[ERR_W-1]}}, err});
        if (!enable) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE:    if (pid_clk_en) next_state = CAPTURE;
                CAPTURE: next_state = MUL_P;
                MUL_P: begin
                    next_state = MUL_I;
                    mac_en     = 1'b1;
                    mac_load   = 1'b1;
                end
                MUL_I: begin
                    next_state  = MUL_D;
                    mac_en      = 1'b1;
                    mac_gain    = $signed(ki);
                    mac_operand = integ;
                end
                MUL_D: begin
                    next_state  = SUM;
                    mac_en      = 1'b1;
                    mac_gain    = $signed(kd);
                    mac_operand = $signed({{(INT_W - DIFF_W){diff[DIFF_W-1]}}, diff});
                end
                SUM:     next_state = IDLE;
                default: next_state = IDLE;
            endcase
        end
    end

    pid_mac #(
        .A_W   (GAIN_W),
        .B_W   (INT_W),
        .ACC_W (ACC_W)
    ) u_mac (
        .clk_12mhz (clk_12mhz),
        .reset_n   (reset_n),
        .clr       (!enable),
        .en        (mac_en),
        .load      (mac_load),
        .gain      (mac_gain),
        .operand   (mac_operand),
        .acc       (acc)
    );

    // Error/integrator/derivative registers, output command and status flags.
    always_ff @(posedge clk_12mhz or negedge reset_n) begin
        // NOTE: non-blocking assignments so every register sees pre-edge values.
        if (!reset_n) begin
            err       <= '0;
            err_prev  <= '0;
            diff      <= '0;
            integ     <= '0;
            out       <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else if (!enable) begin
            err       <= '0;
            err_prev  <= '0;
            diff      <= '0;
            integ     <= '0;
            out       <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (pid_clk_en && busy)
                overrun <= 1'b1;
            case (state)
                IDLE: if (pid_clk_en) err <= err_in;
                CAPTURE: begin
                    diff     <= $signed({err[ERR_W-1], err}) - $signed({err_prev[ERR_W-1], err_prev});
                    err_prev <= err;
                    if (!windup_hold)
                        integ <= integ_next;
                end
                SUM: begin
                    out       <= out_next;
                    out_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
